// File: rtl/pci_target_addr_decoder.sv
// pci_target_addr_decoder
//   Multi-window PCI target address decoder. Detects the address phase (first
//   edge in IDLE with FRAME# low after it was sampled high), compares the
//   address against N_TARGETS programmable base/enable windows using the
//   register values from before that edge, and claims the transaction by
//   driving DEVSEL# low after 1+DEVSEL_DELAY edges. The claim is held until
//   FRAME# and IRDY# are both sampled high.
//
//   Optional build macro: SUBTRACTIVE_DECODE_EN
//     When defined, a decode miss is claimed subtractively four edges after
//     the address phase, with target_sel reporting the miss code N_TARGETS.
//
//   DEVSEL_DELAY must be 0, 1 or 2.
module pci_target_addr_decoder #(
   parameter int N_TARGETS    = 3,
   parameter int ADDR_W       = 32,
   parameter int WIN_BITS     = 4,
   parameter int DEVSEL_DELAY = 1,
   localparam int SEL_W       = $clog2(N_TARGETS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic              frame_n,
   input  logic              irdy_n,
   input  logic              cfg_we,
   input  logic [SEL_W-1:0]  cfg_idx,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic              cfg_en,
   output logic              devsel_n,
   output logic [SEL_W-1:0]  target_sel,
   output logic              claimed
);

   localparam logic [SEL_W-1:0] MISS_SEL = SEL_W'(N_TARGETS);
   localparam logic [2:0]       DLY_CNT  = 3'(DEVSEL_DELAY);

`ifdef SUBTRACTIVE_DECODE_EN
   // Subtractive claims land on edge E+4; cnt_q holds (edges since E) - 1.
   localparam logic [2:0]       SUBTR_CNT = 3'd3;
`endif

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DECODE   = 3'd1,
      ST_CLAIMED  = 3'd2,
      ST_WAIT_END = 3'd3
`ifdef SUBTRACTIVE_DECODE_EN
      ,
      ST_SUBTR    = 3'd4
`endif
   } state_e;

   // Window registers
   logic [ADDR_W-1:0] base_q [N_TARGETS];
   logic [ADDR_W-1:0] base_d [N_TARGETS];
   logic [N_TARGETS-1:0] en_q;
   logic [N_TARGETS-1:0] en_d;

   // Transaction state
   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              hit_lat_q, hit_lat_d;
   logic              frame_prev_q, frame_prev_d;

   // Registered outputs
   logic              devsel_n_q, devsel_n_d;
   logic              claimed_q, claimed_d;
   logic [SEL_W-1:0]  target_sel_q, target_sel_d;

   // Combinational decode
   logic              match_s;
   logic              hit_s;
   logic [SEL_W-1:0]  hit_idx_s;
   logic              bus_idle_s;
   logic              addr_phase_s;

   // Offset bits inside a window never take part in the compare.
   logic              unused_low_bits_s;
   assign unused_low_bits_s = ^{address[WIN_BITS-1:0], cfg_base[WIN_BITS-1:0]};

   // Config write path: a matching index loads base (offset bits cleared) and enable.
   always_comb begin
      base_d = base_q;
      en_d   = en_q;
      for (int i = 0; i < N_TARGETS; i++) begin
         if (cfg_we && (cfg_idx == SEL_W'(i))) begin
            base_d[i] = {cfg_base[ADDR_W-1:WIN_BITS], {WIN_BITS{1'b0}}};
            en_d[i]   = cfg_en;
         end else begin
            base_d[i] = base_q[i];
            en_d[i]   = en_q[i];
         end
      end
   end

   // Window compare; scanning from the top down lets the lowest index win.
   always_comb begin
      match_s   = 1'b0;
      hit_s     = 1'b0;
      hit_idx_s = MISS_SEL;
      for (int i = N_TARGETS - 1; i >= 0; i--) begin
         match_s   = en_q[i] && (address[ADDR_W-1:WIN_BITS] == base_q[i][ADDR_W-1:WIN_BITS]);
         hit_s     = hit_s | match_s;
         hit_idx_s = match_s ? SEL_W'(i) : hit_idx_s;
      end
   end

   assign bus_idle_s   = frame_n & irdy_n;
   assign addr_phase_s = (state_q == ST_IDLE) && !frame_n && frame_prev_q;
   assign frame_prev_d = frame_n;

   // Next-state and registered-output logic of the claim FSM.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sel_d        = sel_q;
      hit_lat_d    = hit_lat_q;
      devsel_n_d   = devsel_n_q;
      claimed_d    = claimed_q;
      target_sel_d = target_sel_q;
      case (state_q)
         ST_IDLE: begin
            if (addr_phase_s) begin
               state_d   = ST_DECODE;
               cnt_d     = 3'd0;
               sel_d     = hit_idx_s;
               hit_lat_d = hit_s;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_DECODE: begin
            if (bus_idle_s) begin
               state_d = ST_IDLE;
            end else if (cnt_q == DLY_CNT) begin
               if (hit_lat_q) begin
                  state_d      = ST_CLAIMED;
                  devsel_n_d   = 1'b0;
                  claimed_d    = 1'b1;
                  target_sel_d = sel_q;
               end else begin
`ifdef SUBTRACTIVE_DECODE_EN
                  state_d = ST_SUBTR;
                  cnt_d   = cnt_q + 3'd1;
`else
                  state_d = ST_WAIT_END;
`endif
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
`ifdef SUBTRACTIVE_DECODE_EN
         ST_SUBTR: begin
            if (bus_idle_s) begin
               state_d = ST_IDLE;
            end else if (cnt_q == SUBTR_CNT) begin
               state_d      = ST_CLAIMED;
               devsel_n_d   = 1'b0;
               claimed_d    = 1'b1;
               target_sel_d = MISS_SEL;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
`endif
         ST_CLAIMED: begin
            if (bus_idle_s) begin
               state_d      = ST_IDLE;
               devsel_n_d   = 1'b1;
               claimed_d    = 1'b0;
               target_sel_d = MISS_SEL;
            end else begin
               state_d      = ST_CLAIMED;
            end
         end
         ST_WAIT_END: begin
            if (bus_idle_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_END;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            devsel_n_d   = 1'b1;
            claimed_d    = 1'b0;
            target_sel_d = MISS_SEL;
         end
      endcase
   end

   // All state and outputs, with synchronous reset to the idle/unprogrammed values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_TARGETS; i++) begin
            base_q[i] <= {ADDR_W{1'b0}};
         end
         en_q         <= {N_TARGETS{1'b0}};
         state_q      <= ST_IDLE;
         cnt_q        <= 3'd0;
         sel_q        <= MISS_SEL;
         hit_lat_q    <= 1'b0;
         frame_prev_q <= 1'b0;
         devsel_n_q   <= 1'b1;
         claimed_q    <= 1'b0;
         target_sel_q <= MISS_SEL;
      end else begin
         base_q       <= base_d;
         en_q         <= en_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sel_q        <= sel_d;
         hit_lat_q    <= hit_lat_d;
         frame_prev_q <= frame_prev_d;
         devsel_n_q   <= devsel_n_d;
         claimed_q    <= claimed_d;
         target_sel_q <= target_sel_d;
      end
   end

   assign devsel_n   = devsel_n_q;
   assign claimed    = claimed_q;
   assign target_sel = target_sel_q;

endmodule

// File: tb/tb_pci_target_addr_decoder.sv
module tb_pci_target_addr_decoder;

   localparam int N     = 3;
   localparam int AW    = 32;
   localparam int WB    = 4;
   localparam int DLY   = 1;
   localparam int SW    = 2;
`ifdef SUBTRACTIVE_DECODE_EN
   localparam bit SUBTR = 1'b1;
`else
   localparam bit SUBTR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] address;
   logic          frame_n;
   logic          irdy_n;
   logic          cfg_we;
   logic [SW-1:0] cfg_idx;
   logic [AW-1:0] cfg_base;
   logic          cfg_en;
   logic          devsel_n;
   logic [SW-1:0] target_sel;
   logic          claimed;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: window bases and enables as the bus sees them.
   logic [AW-1:0] m_base [N];
   logic          m_en   [N];

   pci_target_addr_decoder #(
      .N_TARGETS(N), .ADDR_W(AW), .WIN_BITS(WB), .DEVSEL_DELAY(DLY)
   ) dut (
      .clk(clk), .rst(rst), .address(address), .frame_n(frame_n), .irdy_n(irdy_n),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_en(cfg_en),
      .devsel_n(devsel_n), .target_sel(target_sel), .claimed(claimed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".devsel_n"}, 32'(devsel_n), 32'd1);
      chk({tag, ".claimed"}, 32'(claimed), 32'd0);
      chk({tag, ".target_sel"}, 32'(target_sel), 32'(N));
   endtask

   function automatic int model_decode(input logic [AW-1:0] a);
      for (int i = 0; i < N; i++) begin
         if (m_en[i] && ((a >> WB) == (m_base[i] >> WB))) return i;
      end
      return N;
   endfunction

   function automatic void model_write(input int idx, input logic [AW-1:0] b, input logic e);
      if (idx < N) begin
         m_base[idx] = b;
         m_en[idx]   = e;
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_base[i] = '0;
         m_en[i]   = 1'b0;
      end
   endfunction

   // Claim edge (relative to the address phase) expected for a given decode result.
   function automatic int claim_edge(input int idx);
      if (idx < N) return DLY + 1;
      if (SUBTR) return 4;
      return 1000;
   endfunction

   task automatic cfg_write(input int idx, input logic [AW-1:0] b, input logic e);
      frame_n  = 1'b1;
      irdy_n   = 1'b1;
      cfg_we   = 1'b1;
      cfg_idx  = SW'(idx);
      cfg_base = b;
      cfg_en   = e;
      @(posedge clk);
      model_write(idx, b, e);
      #1;
      cfg_we = 1'b0;
   endtask

   // One transaction: address phase at E, bus goes idle from edge E+idle_at (1..8).
   task automatic txn(input string tag, input logic [AW-1:0] a, input int idle_at,
                      input logic cw, input int cidx, input logic [AW-1:0] cb, input logic ce);
      int exp_idx;
      int ck;
      logic exp_cl;
      exp_idx  = model_decode(a);
      ck       = claim_edge(exp_idx);
      address  = a;
      frame_n  = 1'b0;
      irdy_n   = 1'b0;
      cfg_we   = cw;
      cfg_idx  = SW'(cidx);
      cfg_base = cb;
      cfg_en   = ce;
      @(posedge clk);
      if (cw) model_write(cidx, cb, ce);
      #1;
      cfg_we = 1'b0;
      chk_idle({tag, "@E"});
      for (int k = 1; k <= 8; k++) begin
         if (k >= idle_at) begin
            frame_n = 1'b1;
            irdy_n  = 1'b1;
         end
         @(posedge clk);
         #1;
         exp_cl = (k >= ck) && (k < idle_at);
         chk($sformatf("%s@E+%0d.claimed", tag, k), 32'(claimed), 32'(exp_cl));
         chk($sformatf("%s@E+%0d.devsel_n", tag, k), 32'(devsel_n), 32'(!exp_cl));
         chk($sformatf("%s@E+%0d.target_sel", tag, k), 32'(target_sel),
             exp_cl ? 32'(exp_idx) : 32'(N));
      end
   endtask

   initial begin
      int ia, ib, ab, ex;
      logic [AW-1:0] ra;
      rst = 1'b1; address = '0; frame_n = 1'b1; irdy_n = 1'b1;
      cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_en = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_idle("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic hit, medium timing
      cfg_write(0, 32'h0000_0010, 1'b1);
      txn("t1", 32'h0000_0015, 6, 1'b0, 0, '0, 1'b0);

      // Overlap: lowest index wins
      cfg_write(1, 32'h0000_0020, 1'b1);
      cfg_write(2, 32'h0000_0020, 1'b1);
      txn("t2", 32'h0000_002C, 5, 1'b0, 0, '0, 1'b0);

      // Miss
      txn("t3", 32'h0000_0040, 7, 1'b0, 0, '0, 1'b0);

      // Out-of-range config index is ignored
      cfg_write(3, 32'h0000_0040, 1'b1);
      txn("t3b", 32'h0000_0045, 7, 1'b0, 0, '0, 1'b0);

      // Config write coincident with address phase uses the old base
      txn("t4a", 32'h0000_0015, 6, 1'b1, 0, 32'h0000_0080, 1'b1);
      txn("t4b", 32'h0000_0015, 7, 1'b0, 0, '0, 1'b0);
      txn("t4c", 32'h0000_0085, 6, 1'b0, 0, '0, 1'b0);

      // Reset while claimed
      cfg_write(0, 32'h0000_0010, 1'b1);
      address = 32'h0000_0015; frame_n = 1'b0; irdy_n = 1'b0;
      repeat (DLY + 2) @(posedge clk);
      #1;
      chk("t5.pre.claimed", 32'(claimed), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      model_reset();
      #1;
      chk_idle("t5.rst");
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk_idle("t5.nofresh");
      frame_n = 1'b1; irdy_n = 1'b1;
      @(posedge clk);
      #1;
      txn("t5b", 32'h0000_0015, 7, 1'b0, 0, '0, 1'b0);

      // Abort during decode, then a normal decode
      cfg_write(0, 32'h0000_0010, 1'b1);
      txn("t6a", 32'h0000_0015, 1, 1'b0, 0, '0, 1'b0);
      txn("t6b", 32'h0000_0015, 6, 1'b0, 0, '0, 1'b0);

      // Randomized transactions against the model
      for (int it = 0; it < 24; it++) begin
         ia = $urandom_range(0, 3);
         cfg_write(ia, {24'h0, 4'($urandom_range(1, 8)), 4'($urandom_range(0, 15))},
                   1'($urandom_range(0, 3) != 0));
         ra = {24'h0, 4'($urandom_range(1, 8)), 4'($urandom_range(0, 15))};
         ex = model_decode(ra);
         ab = $urandom_range(1, 8);
         if (ab == claim_edge(ex)) ab = 8;
         ib = $urandom_range(0, 3);
         txn($sformatf("rnd%0d", it), ra, ab, 1'($urandom_range(0, 1)), ib,
             {24'h0, 4'($urandom_range(1, 8)), 4'h0}, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
